// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one neuron per clock through a shared 1-bit truth-table RAM.
// Latency: out_valid rises NEURONS+1 cycles after the input is accepted.
// Backpressure: result held in OUT until out_ready; no input or config accepted outside IDLE.
module lut_layer_sequencer #(
    parameter int NEURONS = 8,
    parameter int FANIN   = 8,
    parameter int NW      = $clog2(NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [NW+FANIN-1:0]      cfg_addr,
    input  logic                     cfg_data,
    output logic                     cfg_ready,
    output logic                     cfg_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NEURONS*FANIN-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEURONS-1:0]       out_data,
    output logic                     busy
);
    localparam int AW    = NW + FANIN;
    localparam int DEPTH = NEURONS * (2 ** FANIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NW-1:0]            r_k;
    logic [NEURONS*FANIN-1:0] r_operand;
    logic [NEURONS-1:0]       r_out_data;
    logic                     r_cfg_err;
    logic                     r_ram [DEPTH];
    logic [AW-1:0]            r_raddr;

    logic                     w_idle;
    logic                     w_cfg_fire;
    logic                     w_in_fire;
    logic                     w_last;
    logic [FANIN-1:0]         w_sel;
    logic [AW-1:0]            w_raddr;
    logic                     w_rdata;

    assign w_idle     = (r_state == S_IDLE);
    assign cfg_ready  = w_idle;
    // Config wins a same-cycle collision with an input vector.
    assign in_ready   = w_idle & ~cfg_we;
    assign w_cfg_fire = cfg_we & w_idle;
    assign w_in_fire  = in_valid & in_ready;
    assign w_last     = (r_k == NW'(NEURONS - 1));
    assign out_valid  = (r_state == S_OUT);
    assign busy       = ~w_idle;
    assign out_data   = r_out_data;
    assign cfg_err    = r_cfg_err;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_in_fire) w_state_nxt = S_EVAL;
            S_EVAL:  if (w_last)    w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Select the fan-in slice of the neuron currently being issued.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NEURONS; i++) begin
            if (r_k == NW'(i)) begin
                w_sel = r_operand[i*FANIN +: FANIN];
            end
        end
    end

    assign w_raddr = {r_k, w_sel};
    assign w_rdata = r_ram[r_raddr];

    // Operand capture, neuron counter and result assembly; read data lags the address by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k        <= '0;
            r_operand  <= '0;
            r_out_data <= '0;
        end else begin
            if (w_in_fire) begin
                r_operand  <= in_data;
                r_k        <= '0;
                r_out_data <= '0;
            end
            if (r_state == S_EVAL) begin
                r_k <= r_k + 1'b1;
                if (r_k != '0) begin
                    r_out_data[r_k - 1'b1] <= w_rdata;
                end
            end
            if (r_state == S_DRAIN) begin
                r_out_data[NEURONS-1] <= w_rdata;
            end
        end
    end

    // Truth-table RAM and its registered read address; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_cfg_fire) begin
            r_ram[cfg_addr] <= cfg_data;
        end
        if (r_state == S_EVAL) begin
            r_raddr <= w_raddr;
        end
    end

    // Sticky flag for config writes attempted while the block is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else if (cfg_we && !cfg_ready) begin
            r_cfg_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Bench for lut_layer_sequencer: directed scenarios plus a randomized sweep.
// A negedge monitor compares every cycle against a latency/phase reference model.
// Tables, inputs and out_ready stalls are randomized in the sweep.
module tb_lut_layer_sequencer;
    localparam int N  = 8;
    localparam int F  = 8;
    localparam int NW = 3;
    localparam int AW = NW + F;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic            cfg_data = 1'b0;
    logic            cfg_ready;
    logic            cfg_err;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*F-1:0]  in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    out_data;
    logic            busy;

    int checks = 0;
    int errors = 0;

    lut_layer_sequencer #(.NEURONS(N), .FANIN(F), .NW(NW)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_ram [N*(2**F)];
    int          m_phase = 0;        // 0 idle, 1 evaluating, 2 result offered
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    logic [N-1:0] m_exp = '0;
    int          cyc = 0;
    int          m_last_acc = -1000;

    function automatic logic [N-1:0] model_eval(input logic [N*F-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k] = m_ram[k * (2**F) + int'(v[k*F +: F])];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_phase    = 0;
            m_cnt      = 0;
            m_err      = 1'b0;
            m_last_acc = -1000;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cfg_err", cfg_err, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_cfg_ready", cfg_ready, 1);
        end else begin
            chk("mon_out_valid", out_valid, m_phase == 2);
            chk("mon_busy", busy, m_phase != 0);
            chk("mon_cfg_ready", cfg_ready, m_phase == 0);
            chk("mon_in_ready", in_ready, (m_phase == 0) && !cfg_we);
            chk("mon_cfg_err", cfg_err, m_err);
            if (m_phase == 2) chk("mon_out_data", out_data, m_exp);
            case (m_phase)
                0: begin
                    if (cfg_we) begin
                        m_ram[int'(cfg_addr)] = cfg_data;
                    end else if (in_valid) begin
                        m_exp = model_eval(in_data);
                        chk("init_interval_ok", (cyc - m_last_acc) >= N + 2, 1);
                        m_last_acc = cyc;
                        m_phase = 1;
                        m_cnt = 0;
                    end
                end
                1: begin
                    if (cfg_we) m_err = 1'b1;
                    m_cnt++;
                    if (m_cnt == N + 1) m_phase = 2;
                end
                default: begin
                    if (cfg_we) m_err = 1'b1;
                    if (out_ready) m_phase = 0;
                end
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cfg_write(input int addr, input bit d);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [N*F-1:0] v);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_data = v;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send: input not accepted within 50 cycles");
        end
    endtask

    task automatic wait_result(input bit rnd, output logic [N-1:0] d, output int lat);
        bit done, seen;
        done = 1'b0; seen = 1'b0; lat = -1; d = '0;
        for (int i = 1; i <= 300 && !done; i++) begin
            out_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            @(negedge clk);
            if (out_valid && !seen) begin seen = 1'b1; lat = i - 1; end
            if (out_valid && out_ready) begin d = out_data; done = 1'b1; end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_result: no out_valid handshake within 300 cycles");
        end
    endtask

    task automatic program_basic();
        for (int i = 0; i < N * (2**F); i++) begin
            cfg_we = 1'b1; cfg_addr = AW'(i);
            cfg_data = (i == 16'h088) || (i == ((7 << F) | 8'hFF));
            @(posedge clk); #1;
        end
        cfg_we = 1'b0;
    endtask

    task automatic program_random();
        for (int i = 0; i < N * (2**F); i++) begin
            cfg_we = 1'b1; cfg_addr = AW'(i); cfg_data = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        logic [N*F-1:0] vec1, vec4, v;
        logic [N-1:0]   d;
        int             lat;
        vec1 = 64'hFF00_0000_0000_0088;
        vec4 = 64'hFF00_0000_1000_0088;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic evaluation with backpressure in OUT.
        program_basic();
        send(vec1);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat = i;
        end
        chk("basic_latency", lat, 9);
        chk("basic_out_data", out_data, 8'b1000_0001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 8'b1000_0001);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        // Config write while busy is dropped and flagged.
        send(vec1);
        cfg_write({3'd0, 8'h88}, 1'b0);
        chk("cfg_busy_err", cfg_err, 1);
        wait_result(1'b0, d, lat);
        chk("cfg_busy_bit0", d[0], 1);
        send(vec1);
        wait_result(1'b0, d, lat);
        chk("cfg_busy_next_eval", d, 8'b1000_0001);

        // Config/input collision in IDLE: config wins, input taken next cycle.
        cfg_we = 1'b1; cfg_addr = {3'd3, 8'h10}; cfg_data = 1'b1;
        in_valid = 1'b1; in_data = vec4;
        @(posedge clk); #1;
        chk("collide_not_taken", busy, 0);
        cfg_we = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("collide_taken_next", busy, 1);
        wait_result(1'b0, d, lat);
        chk("collide_out_data", d, 8'b1000_1001);

        // Asynchronous reset at k=4 of an evaluation.
        send(vec1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_busy", busy, 0);
        chk("areset_cfg_err", cfg_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(vec1);
        wait_result(1'b0, d, lat);
        chk("areset_rerun_data", d, 8'b1000_0001);
        chk("areset_rerun_latency", lat, 9);

        // Randomized sweep with random tables and out_ready stalls.
        program_random();
        for (int n = 0; n < 500; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            v = {$urandom, $urandom};
            send(v);
            wait_result(1'b1, d, lat);
            chk("sweep_out_data", d, model_eval(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
